// File: rtl/doom_arb_pkg.sv
// Shared types and constants for the mem master arbiter and its hookup in doom_fpga.
package doom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // Default watchdog limit: stalled cycles tolerated before the grant is torn down.
    localparam int ARB_TIMEOUT_DEFAULT = 1024;

    // Requester slots used when wiring the command handlers to the arbiter.
    localparam int REQ_PAL = 0;
    localparam int REQ_CHK = 1;
    localparam int REQ_UPD = 2;
    localparam int REQ_PAT = 3;

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: the first active requester strictly after last_owner, wrapping.
module rr_picker
    import doom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] active,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    int                   start;
    int                   offset;

    // Rotate so the slot after last_owner sits at bit 0, take the lowest set bit, undo the rotation.
    always_comb begin
        start   = (int'(last_owner) + 1) % NUM_REQ;
        doubled = {active, active};
        rotated = NUM_REQ'(doubled >> start);
        found   = 1'b0;
        offset  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = i;
            end
        end
        winner = IDX_W'((start + offset) % NUM_REQ);
    end

endmodule

// File: rtl/mem_master_arbiter.sv
// Shares the single Avalon-MM mem master among the command handlers with
// round-robin grants, optional bus lock, and a waitrequest watchdog.
module mem_master_arbiter
    import doom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    input  logic [NUM_REQ-1:0]          req_lock,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [ADDR_W-1:0]           mem_address,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [DATA_W-1:0]           mem_writedata,
    input  logic                        mem_waitrequest,
    input  logic [DATA_W-1:0]           mem_readdata,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err,
    input  logic                        clr_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    arb_state_t         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_owner;
    logic [WD_W-1:0]    wd_cnt;

    logic [NUM_REQ-1:0] active;
    logic               owner_active;
    logic               owner_lock;
    logic               found;
    logic [IDX_W-1:0]   winner;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_address[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_writedata[g*DATA_W +: DATA_W];
    end

    assign active       = req_read | req_write;
    assign owner_active = active[owner];
    assign owner_lock   = req_lock[owner];
    assign req_readdata = mem_readdata;

    rr_picker #(
        .NUM_REQ    (NUM_REQ),
        .IDX_W      (IDX_W)
    ) u_picker (
        .active     (active),
        .last_owner (last_owner),
        .found      (found),
        .winner     (winner)
    );

    // Route the owner onto the master while granted; in ABORT hand the owner a fake completion.
    always_comb begin
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = '0;
        req_waitrequest = '1;
        case (state)
            GRANT: begin
                mem_address            = addr_arr[owner];
                mem_read               = req_read[owner];
                mem_write              = req_write[owner] & ~req_read[owner];
                mem_writedata          = wdata_arr[owner];
                req_waitrequest[owner] = mem_waitrequest;
            end
            ABORT: begin
                req_waitrequest[owner] = 1'b0;
            end
            default: ;
        endcase
    end

    // Arbitration FSM: pick in IDLE, hold through transfers (and locks) in GRANT, abort on watchdog expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= '0;
            last_owner  <= IDX_W'(NUM_REQ - 1);
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            if (clr_err) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        owner    <= winner;
                        grant_id <= winner;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (owner_active && !mem_waitrequest) begin
                        wd_cnt     <= '0;
                        last_owner <= owner;
                        if (!owner_lock) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (owner_active) begin
                        if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                            wd_cnt <= '0;
                            busy   <= 1'b0;
                            state  <= ABORT;
                        end else begin
                            wd_cnt <= wd_cnt + WD_W'(1);
                        end
                    end else if (!owner_lock) begin
                        wd_cnt <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                ABORT: begin
                    timeout_err <= 1'b1;
                    last_owner  <= owner;
                    state       <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master_arbiter.sv
// Directed bench for mem_master_arbiter: reset, single read, round robin,
// locked bursts, reset mid-grant and watchdog abort.
module tb_mem_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 8;

    logic                       clk;
    logic                       reset_n;
    logic [NUM_REQ*ADDR_W-1:0]  req_address;
    logic [NUM_REQ-1:0]         req_read;
    logic [NUM_REQ-1:0]         req_write;
    logic [NUM_REQ*DATA_W-1:0]  req_writedata;
    logic [NUM_REQ-1:0]         req_lock;
    logic [NUM_REQ-1:0]         req_waitrequest;
    logic [DATA_W-1:0]          req_readdata;
    logic [ADDR_W-1:0]          mem_address;
    logic                       mem_read;
    logic                       mem_write;
    logic [DATA_W-1:0]          mem_writedata;
    logic                       mem_waitrequest;
    logic [DATA_W-1:0]          mem_readdata;
    logic [1:0]                 grant_id;
    logic                       busy;
    logic                       timeout_err;
    logic                       clr_err;

    logic [ADDR_W-1:0] addrArr [NUM_REQ];
    logic [DATA_W-1:0] dataArr [NUM_REQ];

    int testsRun;
    int failCount;

    int expOrder [5] = '{0, 2, 3, 0, 2};

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_address[g*ADDR_W +: ADDR_W]   = addrArr[g];
        assign req_writedata[g*DATA_W +: DATA_W] = dataArr[g];
    end

    mem_master_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .TIMEOUT         (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_address     (req_address),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_writedata   (req_writedata),
        .req_lock        (req_lock),
        .req_waitrequest (req_waitrequest),
        .req_readdata    (req_readdata),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .grant_id        (grant_id),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .clr_err         (clr_err)
    );

    // 10 ns clock; rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive the per-requester strobes and the slave side, then let combinational paths settle.
    task automatic applyStimulus(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] lk,
                                 input logic mw, input logic [7:0] rdata);
        req_read        = rd;
        req_write       = wr;
        req_lock        = lk;
        mem_waitrequest = mw;
        mem_readdata    = rdata;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        testsRun  = 0;
        failCount = 0;
        reset_n   = 1'b0;
        clr_err   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addrArr[i] = '0;
            dataArr[i] = '0;
        end
        req_read        = '0;
        req_write       = '0;
        req_lock        = '0;
        mem_waitrequest = 1'b0;
        mem_readdata    = '0;

        // Reset state and idling with no requests
        #22 reset_n = 1'b1;
        #1;
        checkOutput("rst_waitreq",  32'(req_waitrequest), 32'hF);
        checkOutput("rst_busy",     32'(busy), 32'h0);
        checkOutput("rst_grant",    32'(grant_id), 32'h0);
        checkOutput("rst_strobes",  32'({mem_read, mem_write}), 32'h0);
        checkOutput("rst_addr",     mem_address, 32'h0);
        checkOutput("rst_err",      32'(timeout_err), 32'h0);
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput("idle_waitreq", 32'(req_waitrequest), 32'hF);
            checkOutput("idle_busy",    32'({busy, mem_read, mem_write}), 32'h0);
            checkOutput("idle_grant",   32'(grant_id), 32'h0);
        end

        // Req1 read of 0x100, two stall cycles, data 0xA5
        addrArr[1] = 32'h100;
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b1, 8'h00);
        checkOutput("rd_pre_busy", 32'(busy), 32'h0);
        stepCycle();
        checkOutput("rd_c1_busy",    32'(busy), 32'h1);
        checkOutput("rd_c1_grant",   32'(grant_id), 32'h1);
        checkOutput("rd_c1_read",    32'(mem_read), 32'h1);
        checkOutput("rd_c1_addr",    mem_address, 32'h100);
        checkOutput("rd_c1_waitreq", 32'(req_waitrequest), 32'hF);
        stepCycle();
        checkOutput("rd_c2_waitreq", 32'(req_waitrequest), 32'hF);
        stepCycle();
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0, 8'hA5);
        checkOutput("rd_c3_waitreq", 32'(req_waitrequest), 32'hD);
        checkOutput("rd_c3_rdata",   32'(req_readdata), 32'hA5);
        stepCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00);
        checkOutput("rd_c4_busy",  32'(busy), 32'h0);
        checkOutput("rd_c4_read",  32'(mem_read), 32'h0);
        checkOutput("rd_c4_grant", 32'(grant_id), 32'h1);

        // Round robin among 0, 2, 3 from a fresh reset, zero-wait slave
        stepCycle();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        addrArr[0] = 32'h200; dataArr[0] = 8'h11;
        addrArr[2] = 32'h202; dataArr[2] = 8'h22;
        addrArr[3] = 32'h203; dataArr[3] = 8'h33;
        applyStimulus(4'b0000, 4'b1101, 4'b0000, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkOutput("rr_busy",    32'(busy), 32'h1);
            checkOutput("rr_grant",   32'(grant_id), 32'(expOrder[k]));
            checkOutput("rr_write",   32'(mem_write), 32'h1);
            checkOutput("rr_wdata",   32'(mem_writedata), 32'(dataArr[expOrder[k]]));
            checkOutput("rr_waitreq", 32'(req_waitrequest), 32'(4'hF & ~(4'h1 << expOrder[k])));
            stepCycle();
            checkOutput("rr_gap_busy",  32'(busy), 32'h0);
            checkOutput("rr_gap_write", 32'(mem_write), 32'h0);
        end

        // Req2 locked burst to 0x10..0x13 while req0 waits
        addrArr[2] = 32'h10; dataArr[2] = 8'h40;
        addrArr[0] = 32'h300; dataArr[0] = 8'h50;
        applyStimulus(4'b0000, 4'b0100, 4'b0100, 1'b0, 8'h00);
        for (int b = 0; b < 4; b++) begin
            stepCycle();
            addrArr[2] = 32'h10 + 32'(b);
            dataArr[2] = 8'h40 + 8'(b);
            applyStimulus(4'b0000, 4'b0101, 4'b0100, 1'b0, 8'h00);
            checkOutput("lk_busy",    32'(busy), 32'h1);
            checkOutput("lk_grant",   32'(grant_id), 32'h2);
            checkOutput("lk_write",   32'(mem_write), 32'h1);
            checkOutput("lk_addr",    mem_address, 32'h10 + 32'(b));
            checkOutput("lk_wdata",   32'(mem_writedata), 32'h40 + 32'(b));
            checkOutput("lk_waitreq", 32'(req_waitrequest), 32'hB);
        end
        stepCycle();
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 1'b0, 8'h00);
        checkOutput("lk_rel_write",   32'(mem_write), 32'h0);
        checkOutput("lk_rel_grant",   32'(grant_id), 32'h2);
        checkOutput("lk_rel_waitreq", 32'(req_waitrequest), 32'hB);
        stepCycle();
        checkOutput("lk_gap_busy", 32'(busy), 32'h0);
        stepCycle();
        checkOutput("lk_r0_busy",  32'(busy), 32'h1);
        checkOutput("lk_r0_grant", 32'(grant_id), 32'h0);
        checkOutput("lk_r0_addr",  mem_address, 32'h300);
        stepCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00);
        checkOutput("lk_end_busy", 32'(busy), 32'h0);

        // Reset mid-grant drops the write at once and restores last_owner to 3
        addrArr[3] = 32'h400; dataArr[3] = 8'h66;
        applyStimulus(4'b0000, 4'b1000, 4'b0000, 1'b1, 8'h00);
        stepCycle();
        checkOutput("mr_write_pre", 32'(mem_write), 32'h1);
        checkOutput("mr_grant_pre", 32'(grant_id), 32'h3);
        reset_n = 1'b0;
        #1;
        checkOutput("mr_write",   32'(mem_write), 32'h0);
        checkOutput("mr_addr",    mem_address, 32'h0);
        checkOutput("mr_busy",    32'(busy), 32'h0);
        checkOutput("mr_grant",   32'(grant_id), 32'h0);
        checkOutput("mr_waitreq", 32'(req_waitrequest), 32'hF);
        reset_n    = 1'b1;
        addrArr[1] = 32'h500;
        applyStimulus(4'b0000, 4'b0011, 4'b0000, 1'b0, 8'h00);
        stepCycle();
        checkOutput("mr_next_busy", 32'(busy), 32'h1);
        checkOutput("mr_next_addr", mem_address, 32'h300);
        stepCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00);
        checkOutput("mr_end_busy", 32'(busy), 32'h0);

        // Req3 read against a stuck slave: abort after 8 stalls, sticky error, clear
        addrArr[3] = 32'h600;
        applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b1, 8'h00);
        stepCycle();
        checkOutput("to_grant", 32'(grant_id), 32'h3);
        checkOutput("to_read",  32'(mem_read), 32'h1);
        for (int s = 0; s < 7; s++) begin
            stepCycle();
        end
        checkOutput("to_s8_busy",    32'(busy), 32'h1);
        checkOutput("to_s8_waitreq", 32'(req_waitrequest), 32'hF);
        stepCycle();
        checkOutput("to_ab_busy",    32'(busy), 32'h0);
        checkOutput("to_ab_read",    32'(mem_read), 32'h0);
        checkOutput("to_ab_waitreq", 32'(req_waitrequest), 32'h7);
        checkOutput("to_ab_err",     32'(timeout_err), 32'h0);
        clr_err = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 8'h00);
        stepCycle();
        clr_err = 1'b0;
        checkOutput("to_err_set",  32'(timeout_err), 32'h1);
        checkOutput("to_post_wr",  32'(req_waitrequest), 32'hF);
        stepCycle();
        checkOutput("to_err_hold", 32'(timeout_err), 32'h1);
        clr_err = 1'b1;
        stepCycle();
        clr_err = 1'b0;
        checkOutput("to_err_clr", 32'(timeout_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/mem_master_arbiter.md
Name: mem_master_arbiter

Overview:
- Shares the single 8-bit Avalon-MM mem master among the command handlers: palette, selfcheck, update and patch.
- Round-robin arbitration with an optional lock, so a handler can hold the bus across a multi-beat sequence.
- A waitrequest watchdog prevents a stalled handler from hanging the top-level command FSM.
- Sits between the handler instances and the mem_master port of doom_fpga; replaces the state-indexed mux.

Parameters:
- NUM_REQ, 4, number of requesters (indices 0..NUM_REQ-1).
- ADDR_W, 32, address width.
- DATA_W, 8, data width.
- TIMEOUT, 1024, master waitrequest-high cycles before abort; must be ≥2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_address  in  NUM_REQ*ADDR_W  per-requester address; slice i belongs to requester i.
- req_read  in  NUM_REQ  per-requester read strobe.
- req_write  in  NUM_REQ  per-requester write strobe.
- req_writedata  in  NUM_REQ*DATA_W  per-requester write data.
- req_lock  in  NUM_REQ  hold the grant after the current transfer.
- req_waitrequest  out  NUM_REQ  per-requester stall.
- req_readdata  out  DATA_W  master readdata, broadcast to all requesters.
- mem_address  out  ADDR_W  master address.
- mem_read  out  1  master read strobe.
- mem_write  out  1  master write strobe.
- mem_writedata  out  DATA_W  master write data.
- mem_waitrequest  in  1  master stall.
- mem_readdata  in  DATA_W  master read data; valid in the cycle waitrequest is low.
- grant_id  out  $clog2(NUM_REQ)  current or last owner, for debug display.
- busy  out  1  a grant is active.
- timeout_err  out  1  sticky; set on watchdog abort.
- clr_err  in  1  clears timeout_err.

Behaviour:
- Reset (async on reset_n low):
  - state=IDLE, last_owner=NUM_REQ-1, grant_id=0, busy=0, timeout_err=0, wd_cnt=0.
  - req_waitrequest all ones.
  - mem_read/mem_write/mem_address/mem_writedata all 0.
  - Reset mid-transfer drops the master strobes the same cycle.
- A requester is active when req_read[i]|req_write[i]. Asserting both at once is illegal; read wins.
- States: IDLE, GRANT, ABORT.
- IDLE:
  - mem_* strobes 0; all req_waitrequest=1.
  - If any requester is active, choose the first active index strictly after last_owner, wrapping modulo NUM_REQ.
  - Register owner and grant_id, go to GRANT next cycle. Arbitration latency is 1 cycle.
- GRANT:
  - Owner's address, read, write and writedata drive mem_* combinationally.
  - req_waitrequest[owner]=mem_waitrequest; all others stay 1.
  - busy=1.
  - A transfer completes in a cycle with the owner active and mem_waitrequest=0. On completion:
    - wd_cnt←0 and last_owner←owner.
    - If req_lock[owner]=1, stay in GRANT; back-to-back transfers run with no bubble.
    - Otherwise go to IDLE; at least one idle cycle precedes the next grant.
  - Owner inactive with req_lock[owner]=0 → IDLE with no transfer; last_owner is unchanged.
  - Owner inactive with lock=1 → stay in GRANT, holding the bus.
  - wd_cnt increments each cycle the owner is active and mem_waitrequest=1. When wd_cnt reaches TIMEOUT-1 → ABORT.
- ABORT:
  - One cycle. mem strobes 0; req_waitrequest[owner]=0 so the owner sees a bogus completion; readdata is undefined.
  - timeout_err←1; last_owner←owner; then IDLE.
- timeout_err clears only on clr_err=1 in a cycle with no simultaneous abort. If both occur, set wins.
- req_readdata = mem_readdata, unregistered.
- Non-owners asserting strobes are ignored; their requests stay pending and are served in round-robin order.

Decomposition:
- Package doom_arb_pkg holds:
  - the arb_state_t enum {IDLE, GRANT, ABORT};
  - the localparam for default TIMEOUT;
  - the requester index constants REQ_PAL=0, REQ_CHK=1, REQ_UPD=2, REQ_PAT=3, for the top-level hookup.
- One sub-module: rr_picker. It is purely combinational.
  - Inputs: active vector, last_owner.
  - Outputs: found flag, winner index.
  - Implementation: rotate, priority-encode, add offset modulo NUM_REQ.

Test Plan:
- Reset release, no requests → all req_waitrequest=1, mem_read=mem_write=0, busy=0, grant_id=0 indefinitely.
- Req1 reads 0x100 with mem_waitrequest low after 2 cycles, readdata 0xA5:
  - grant is visible on cycle 1;
  - req_waitrequest[1] goes low on cycle 3 with req_readdata=0xA5;
  - the arbiter is in IDLE on cycle 4.
- Reqs 0, 2, 3 all write continuously, zero-wait slave, lock=0 → grant order 0, 2, 3, 0, 2 …, each transfer separated by one idle cycle.
- Req2 lock=1 issues 4 writes to 0x10..0x13 while req0 also requests:
  - all 4 writes appear on consecutive cycles;
  - req0 is granted only after req2 drops lock and strobes.
- Req3 reads with mem_waitrequest stuck high, TIMEOUT=8:
  - ABORT is entered after 8 stalled cycles;
  - req_waitrequest[3]=0 for 1 cycle and timeout_err=1;
  - timeout_err clears one cycle after clr_err is pulsed.
- reset_n asserted low mid-GRANT while mem_write=1 → mem_write=0 immediately (asynchronous), state=IDLE, last_owner=NUM_REQ-1.
